// File: rtl/ama_riscv_reg_file.sv
// RV32I integer register file: x1..x31 with two combinational read ports,
// one synchronous write port and optional same-cycle write forwarding.
module ama_riscv_reg_file #(
  parameter bit          BYPASS_EN = 1'b1,
  parameter logic [31:0] RST_VAL   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  addr_a,
  input  logic [4:0]  addr_b,
  input  logic [4:0]  addr_d,
  input  logic [31:0] data_d,
  output logic [31:0] data_a,
  output logic [31:0] data_b
);

  logic [31:0] regs_q [31:1];
  logic        wr_hit;

  // x0 is hard-wired, so index 0 never writes and never forwards
  assign wr_hit = we & ~rst & (addr_d != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= RST_VAL;
      end
    end else if (wr_hit) begin
      regs_q[addr_d] <= data_d;
    end
  end

  always_comb begin
    data_a = 32'h0;
    if (addr_a != 5'd0) begin
      if (BYPASS_EN && wr_hit && (addr_a == addr_d)) begin
        data_a = data_d;
      end else begin
        data_a = regs_q[addr_a];
      end
    end
  end

  always_comb begin
    data_b = 32'h0;
    if (addr_b != 5'd0) begin
      if (BYPASS_EN && wr_hit && (addr_b == addr_d)) begin
        data_b = data_d;
      end else begin
        data_b = regs_q[addr_b];
      end
    end
  end

endmodule
